// File: rtl/clk_prescaler_if.sv
// clk_prescaler_if: ratio input and divided outputs for one prescaler.
//   iDIV   divide ratio N (master -> slave)
//   oCLK   divided clock, period N input clocks (slave -> master)
//   oTICK  one-cycle strobe coincident with each oCLK rise (slave -> master)
interface clk_prescaler_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] iDIV;
    logic             oCLK;
    logic             oTICK;

    modport master (output iDIV, input  oCLK, input  oTICK);
    modport slave  (input  iDIV, output oCLK, output oTICK);
endinterface

// File: rtl/clk_prescaler.sv
// clk_prescaler: programmable integer clock divider.
//   iCLK    input clock, all logic on posedge
//   iRST_N  asynchronous active-low reset
//   bus     slave side of clk_prescaler_if:
//             iDIV  ratio N (0 = stop, 1 behaves as 2)
//             oCLK  registered divided clock, high E/2 cycles then low
//             oTICK registered one-cycle pulse with each oCLK rise
// Both outputs come straight from flops, so oCLK is glitch-free and may clock
// a further prescaler in cascade.
module clk_prescaler #(
    parameter int WIDTH = 8
) (
    input  logic           iCLK,
    input  logic           iRST_N,
    clk_prescaler_if.slave bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] eff;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;

    // A ratio of 1 cannot produce a high and a low phase, so it runs as 2.
    assign eff     = (div_q == WIDTH'(1)) ? WIDTH'(2) : div_q;
    assign half    = eff >> 1;
    // cnt_q stays at or below eff-1 (<= 2^WIDTH-2), so the increment never wraps.
    assign cnt_inc = cnt_q + WIDTH'(1);

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (div_q == '0) begin
            // Stopped: keep sampling the ratio every cycle.
            div_d = bus.iDIV;
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (cnt_q == eff - WIDTH'(1)) begin
            // Period boundary: the new ratio applies to the period starting
            // here, and a zero ratio parks the divider without a rise.
            cnt_d  = '0;
            div_d  = bus.iDIV;
            clk_d  = (bus.iDIV != '0);
            tick_d = (bus.iDIV != '0);
        end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == half) clk_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q  <= '0;
            div_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign bus.oCLK  = clk_q;
    assign bus.oTICK = tick_q;

endmodule

// File: tb/tb_clk_prescaler.sv
// tb_clk_prescaler: randomized and directed checks of clk_prescaler against a
// phase-queue reference model, plus async reset and a 16 x 2 cascade.
module tb_clk_prescaler;
    localparam int W = 8;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b1;

    clk_prescaler_if #(.WIDTH(W)) bus ();
    clk_prescaler_if #(.WIDTH(W)) cbus ();

    clk_prescaler #(.WIDTH(W)) dut  (.iCLK(iCLK),     .iRST_N(iRST_N), .bus(bus));
    clk_prescaler #(.WIDTH(W)) dut2 (.iCLK(bus.oCLK), .iRST_N(iRST_N), .bus(cbus));

    always #5 iCLK = ~iCLK;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d exp %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of expected {clk,tick} for upcoming edges.
    // A period of ratio E is queued as a rise, half-1 more high edges, then
    // E-half low edges; startup from stop is E edges of low.
    typedef struct packed { logic c; logic t; } exp_t;
    exp_t q[$];
    bit   m_run;
    exp_t e;

    function automatic int eff_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : d);
    endfunction

    task automatic model_edge(input int d);
        int ee, h;
        if (q.size() != 0) begin
            e = q.pop_front();
        end else if (!m_run) begin
            e = '0;
            if (d != 0) begin
                for (int i = 0; i < eff_of(d) - 1; i++) q.push_back('0);
                m_run = 1;
            end
        end else if (d == 0) begin
            e = '0;
            m_run = 0;
        end else begin
            ee = eff_of(d);
            h  = ee / 2;
            e  = '{c: 1'b1, t: 1'b1};
            for (int i = 0; i < h - 1; i++) q.push_back('{c: 1'b1, t: 1'b0});
            for (int i = 0; i < ee - h; i++) q.push_back('0);
        end
    endtask

    int cyc;

    task automatic step();
        model_edge(int'(bus.iDIV));
        @(posedge iCLK);
        #1;
        cyc++;
        chk("oCLK",  int'(bus.oCLK),  int'(e.c));
        chk("oTICK", int'(bus.oTICK), int'(e.t));
    endtask

    task automatic do_reset(input int n);
        iRST_N = 1'b0;
        q.delete();
        m_run = 0;
        repeat (n) begin
            @(posedge iCLK);
            #1;
            chk("rst_clk",  int'(bus.oCLK),  0);
            chk("rst_tick", int'(bus.oTICK), 0);
        end
        iRST_N = 1'b1;
        cyc = 0;
    endtask

    longint crise[$];
    always @(posedge cbus.oCLK) crise.push_back(longint'($time));

    initial begin
        int first, d, len;
        bit seen;
        bus.iDIV  = 8'd16;
        cbus.iDIV = 8'd2;
        #1;
        do_reset(4);

        // Startup with 16: first tick on edge 17, cascade period 32.
        first = 0;
        crise.delete();
        repeat (200) begin
            step();
            if (bus.oTICK && first == 0) first = cyc;
        end
        chk("first_rise16", first, 17);
        if (crise.size() >= 3)
            chk("casc_period", int'((crise[crise.size()-1] - crise[crise.size()-2]) / 10), 32);
        else
            chk("casc_rises", crise.size(), 3);

        // Mid-period change 16 -> 4.
        repeat (5) step();
        bus.iDIV = 8'd4;
        repeat (40) step();

        // Stop, then restart at 16: rise 17 edges after the restart sample.
        bus.iDIV = 8'd0;
        repeat (30) step();
        chk("stopped_clk", int'(bus.oCLK), 0);
        bus.iDIV = 8'd16;
        first = 0;
        repeat (20) begin
            step();
            if (bus.oTICK && first == 0) first = cyc;
        end
        chk("restart_nonzero", int'(first != 0), 1);

        // Async reset mid-high: oCLK must fall without an iCLK edge.
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (bus.oCLK) seen = 1;
        end
        chk("found_high", int'(seen), 1);
        #2;
        iRST_N = 1'b0;
        #1;
        chk("async_rst_clk", int'(bus.oCLK), 0);
        do_reset(3);

        // Randomized ratios and hold times.
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 9))
                0: d = 0;
                1: d = 1;
                2: d = 2;
                3: d = 3;
                4: d = 255;
                default: d = int'($urandom_range(2, 40));
            endcase
            bus.iDIV = W'(d);
            len = (d == 255) ? 560 : int'($urandom_range(1, 90));
            repeat (len) step();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
